// File: rtl/sram1rw_param.sv
// Parametrised single-port (1RW) synchronous SRAM model.
// After every reset a clear engine walks the whole array and writes zeros,
// so simulations start from known contents.  Requests are only accepted once
// READY is high.  Reads are read-first with respect to a same-cycle write.
// The write mask is active-low, with one bit per MASK_GRAN-bit lane.
// OUT_REG selects a read latency of one or two cycles.
module sram1rw_param #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 22,
   parameter int MASK_GRAN  = 11,
   parameter int OUT_REG    = 0
) (
   input  logic                            CE,
   input  logic                            RST,
   input  logic                            CSB,
   input  logic                            WEB,
   input  logic                            OEB,
   input  logic [ADDR_WIDTH-1:0]           A,
   input  logic [DATA_WIDTH-1:0]           I,
   input  logic [DATA_WIDTH/MASK_GRAN-1:0] WMB,
   output logic [DATA_WIDTH-1:0]           O,
   output logic                            OVALID,
   output logic                            READY
);

   localparam int NLANES = DATA_WIDTH / MASK_GRAN;
   localparam int DEPTH  = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   clr_cnt_reg, clr_cnt_next;
   logic                    clearing;
   logic                    re_acc;
   logic                    we_acc;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    rd_valid_reg;

   assign clearing = (state_reg == CLEAR);
   assign READY    = (state_reg == RUN);

   // Requests count only once the clear has finished.
   // Reset priority is applied inside the clocked blocks.
   assign re_acc = READY & ~CSB & ~OEB;
   assign we_acc = READY & ~CSB & ~WEB;

   // State and clear-counter registers.
   // Reset restarts the clear sequence from address 0.
   always_ff @(posedge CE) begin
      if (RST) begin
         state_reg   <= CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   // Next-state logic.
   // The last clear write hands over to RUN, which holds until reset.
   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      case (state_reg)
         CLEAR: begin
            clr_cnt_next = clr_cnt_reg + ADDR_WIDTH'(1);
            if (clr_cnt_reg == LAST_ADDR) begin
               state_next = RUN;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next = CLEAR;
         end
      endcase
   end

   // Each mask lane has its own storage array.  This keeps lane writes
   // independent and lets each lane map onto a plain RAM.
   generate
      for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
         logic [MASK_GRAN-1:0] mem [DEPTH];
         logic [MASK_GRAN-1:0] rd_lane_reg;

         // Clear-engine writes and masked user writes go to the array.
         // The read is registered and samples the old contents (read-first).
         always_ff @(posedge CE) begin
            if (RST) begin
               rd_lane_reg <= '0;
            end else begin
               if (clearing) begin
                  mem[clr_cnt_reg] <= '0;
               end else if (we_acc && !WMB[gi]) begin
                  mem[A] <= I[gi*MASK_GRAN +: MASK_GRAN];
               end
               if (re_acc) begin
                  rd_lane_reg <= mem[A];
               end
            end
         end

         assign rd_word[gi*MASK_GRAN +: MASK_GRAN] = rd_lane_reg;
      end
   endgenerate

   // First-stage valid flag.
   // It pulses for exactly one cycle per accepted read.
   always_ff @(posedge CE) begin
      if (RST) begin
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= re_acc;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] o_reg;
         logic                  ovalid_reg;

         // Extra output stage.
         // Reset drops any read still in flight.
         always_ff @(posedge CE) begin
            if (RST) begin
               o_reg      <= '0;
               ovalid_reg <= 1'b0;
            end else begin
               ovalid_reg <= rd_valid_reg;
               if (rd_valid_reg) begin
                  o_reg <= rd_word;
               end
            end
         end

         assign O      = o_reg;
         assign OVALID = ovalid_reg;
      end else begin : g_no_out_reg
         assign O      = rd_word;
         assign OVALID = rd_valid_reg;
      end
   endgenerate

endmodule

// File: tb/tb_sram1rw_param.sv
// Testbench for sram1rw_param.
// It runs two instances, one with OUT_REG=0 and one with OUT_REG=1, from the
// same stimulus.  A memory model and per-instance queues give the expected
// read data and the cycle it must appear in.
module tb_sram1rw_param;

   logic        CE = 1'b0;
   logic        RST;
   logic        CSB;
   logic        WEB;
   logic        OEB;
   logic [5:0]  A;
   logic [21:0] I;
   logic [1:0]  WMB;
   logic [21:0] O0, O1;
   logic        OVALID0, OVALID1;
   logic        READY0, READY1;

   typedef struct {
      logic [21:0] d;
      int          due;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [21:0] model [64];
   int          cycle = 0;
   int          total = 0;
   int          bad   = 0;

   always #5 CE = ~CE;

   sram1rw_param #(.ADDR_WIDTH(6), .DATA_WIDTH(22), .MASK_GRAN(11), .OUT_REG(0)) u0 (
      .CE(CE), .RST(RST), .CSB(CSB), .WEB(WEB), .OEB(OEB), .A(A), .I(I), .WMB(WMB),
      .O(O0), .OVALID(OVALID0), .READY(READY0)
   );

   sram1rw_param #(.ADDR_WIDTH(6), .DATA_WIDTH(22), .MASK_GRAN(11), .OUT_REG(1)) u1 (
      .CE(CE), .RST(RST), .CSB(CSB), .WEB(WEB), .OEB(OEB), .A(A), .I(I), .WMB(WMB),
      .O(O1), .OVALID(OVALID1), .READY(READY1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, expv);
      end
   endtask

   task automatic idle();
      CSB = 1'b1;
      WEB = 1'b1;
      OEB = 1'b1;
      A   = '0;
      I   = '0;
      WMB = 2'b11;
   endtask

   // Advance one edge, sample 1 ns later, and check both output ports
   // against the head of their scoreboard queues.
   task automatic tick();
      @(posedge CE);
      #1;
      cycle++;
      if (q0.size() > 0 && q0[0].due == cycle) begin
         chk("ovalid0", 32'(OVALID0), 32'd1);
         chk("o0", 32'(O0), 32'(q0[0].d));
         $display("cycle %0d out_reg0 read data=%h", cycle, O0);
         void'(q0.pop_front());
      end else begin
         chk("ovalid0_idle", 32'(OVALID0), 32'd0);
      end
      if (q1.size() > 0 && q1[0].due == cycle) begin
         chk("ovalid1", 32'(OVALID1), 32'd1);
         chk("o1", 32'(O1), 32'(q1[0].d));
         $display("cycle %0d out_reg1 read data=%h", cycle, O1);
         void'(q1.pop_front());
      end else begin
         chk("ovalid1_idle", 32'(OVALID1), 32'd0);
      end
   endtask

   // Drive one request for a single edge.  When acc is set, the request is
   // known to be accepted, so the expected read is queued (read-first) and
   // the model is updated.
   task automatic drive(input logic csb, input logic web, input logic oeb,
                        input logic [5:0] a, input logic [21:0] i,
                        input logic [1:0] wmb, input bit acc);
      exp_t        e;
      logic [21:0] nw;
      CSB = csb;
      WEB = web;
      OEB = oeb;
      A   = a;
      I   = i;
      WMB = wmb;
      if (acc && !csb && !oeb) begin
         e.d   = model[a];
         e.due = cycle + 1;
         q0.push_back(e);
         e.due = cycle + 2;
         q1.push_back(e);
      end
      if (acc && !csb && !web) begin
         nw = model[a];
         for (int n = 0; n < 2; n++) begin
            if (!wmb[n]) nw[n*11 +: 11] = i[n*11 +: 11];
         end
         model[a] = nw;
      end
      tick();
      idle();
   endtask

   // Run the clear sequence after reset release.  READY must be low for
   // 63 edges and first high after the 64th.  When ign > 0, a write plus
   // read to A=3 is issued at that step; it must be ignored.
   task automatic clear_seq(input int ign);
      for (int j = 1; j <= 64; j++) begin
         if (j == ign) begin
            CSB = 1'b0;
            WEB = 1'b0;
            OEB = 1'b0;
            A   = 6'd3;
            I   = 22'h12345;
            WMB = 2'b00;
         end else begin
            idle();
         end
         tick();
         chk("ready0", 32'(READY0), 32'(j == 64));
         chk("ready1", 32'(READY1), 32'(j == 64));
      end
      idle();
      for (int k = 0; k < 64; k++) model[k] = '0;
      $display("cycle %0d clear sequence complete", cycle);
   endtask

   task automatic drain();
      for (int k = 0; k < 3; k++) tick();
   endtask

   initial begin
      idle();
      RST = 1'b1;
      for (int k = 0; k < 64; k++) model[k] = '0;

      // Reset state.
      tick();
      tick();
      chk("rst_o0", 32'(O0), 32'd0);
      chk("rst_o1", 32'(O1), 32'd0);
      chk("rst_ready0", 32'(READY0), 32'd0);
      chk("rst_ready1", 32'(READY1), 32'd0);
      $display("cycle %0d reset state checked", cycle);
      RST = 1'b0;

      // Clear sequence, with an ignored write+read to A=3 at clear count 60.
      clear_seq(61);

      // Read back the whole array: all zero, one OVALID per read.
      for (int k = 0; k < 64; k++) begin
         drive(1'b0, 1'b1, 1'b0, 6'(k), 22'h0, 2'b11, 1'b1);
      end
      drain();

      // Masked write.
      drive(1'b0, 1'b0, 1'b1, 6'd5, 22'h3FFFFF, 2'b00, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 6'd5, 22'h000000, 2'b10, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd5, 22'h0, 2'b11, 1'b1);
      drain();
      chk("mask_model", 32'(model[5]), 32'h3FF800);

      // All-ones mask is a no-op write.
      drive(1'b0, 1'b0, 1'b1, 6'd5, 22'h123456, 2'b11, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd5, 22'h0, 2'b11, 1'b1);
      drain();

      // Back-to-back reads at A=1,2,3.
      drive(1'b0, 1'b0, 1'b1, 6'd1, 22'h111111, 2'b00, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 6'd2, 22'h222222, 2'b00, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 6'd3, 22'h333333, 2'b00, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd1, 22'h0, 2'b11, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd2, 22'h0, 2'b11, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd3, 22'h0, 2'b11, 1'b1);
      drain();

      // Read-during-write on the same address returns the old data.
      drive(1'b0, 1'b0, 1'b1, 6'd9, 22'h000AAA, 2'b00, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 6'd9, 22'h155555, 2'b00, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd9, 22'h0, 2'b11, 1'b1);
      drain();

      // Mixed random traffic.
      for (int k = 0; k < 40; k++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
               22'($urandom), 2'($urandom_range(0, 3)), 1'b1);
      end
      drain();

      // Reset in RUN, then again at clear count 30.
      q0.delete();
      q1.delete();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         chk("midclr_ready0", 32'(READY0), 32'd0);
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      clear_seq(0);
      drive(1'b0, 1'b1, 1'b0, 6'd5, 22'h0, 2'b11, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd9, 22'h0, 2'b11, 1'b1);
      drain();

      // Reset with a read in flight in the OUT_REG=1 pipeline.
      drive(1'b0, 1'b0, 1'b1, 6'd7, 22'h2ABCDE, 2'b00, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 6'd7, 22'h0, 2'b11, 1'b1);
      q1.delete();
      RST = 1'b1;
      tick();
      chk("inflight_o0", 32'(O0), 32'd0);
      chk("inflight_o1", 32'(O1), 32'd0);
      RST = 1'b0;
      clear_seq(0);
      drive(1'b0, 1'b1, 1'b0, 6'd7, 22'h0, 2'b11, 1'b1);
      drain();

      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
